// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // One buffered write-back: destination register and its value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the execution units and the write-back arbiter.
// The arbiter takes the slave modport; the producers take the master modport.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;

  logic                  md_valid;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  md_ready;

  logic                  md_issue;
  logic [REG_ADDR_W-1:0] md_issue_rd;

  logic                  wb_writeEnable;
  logic [REG_ADDR_W-1:0] wb_writeReg;
  logic [DATA_W-1:0]     wb_data;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output md_valid, md_rd, md_data,
    output md_issue, md_issue_rd,
    input  alu_ready, md_ready,
    input  wb_writeEnable, wb_writeReg, wb_data, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  md_valid, md_rd, md_data,
    input  md_issue, md_issue_rd,
    output alu_ready, md_ready,
    output wb_writeEnable, wb_writeReg, wb_data, busy_mask
  );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO buffering multdiv results until they win the write port.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      ctrl_reset,
  input  logic      push,
  input  wb_entry_t pushEntry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [CntW-1:0] count;
  logic            doPush;
  logic            doPop;

  assign full   = (count == CntW'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rdPtr];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Advance pointers and track occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)  rdPtr <= rdPtr + PtrW'(1);
      if (doPush && !doPop)      count <= count + CntW'(1);
      else if (doPop && !doPush) count <= count - CntW'(1);
    end
  end

  // Entry storage needs no reset: only slots covered by the count are ever read as valid.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares one register-file write port between the
// single-cycle ALU and buffered multdiv results, and keeps a busy scoreboard
// of registers waiting on multdiv.
// Optional feature macro: WB_STARVE_GUARD_EN -- when defined, a starve counter
// forces the buffered multdiv head through after STARVE_LIMIT ALU wins.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clock,
  input logic         ctrl_reset,
  wb_arbiter_if.slave bus
);

  logic                  fifoFull;
  logic                  fifoEmpty;
  wb_entry_t             fifoHead;
  wb_entry_t             pushEntry;
  logic                  fifoPush;
  logic                  starveFlag;
  logic                  aluWin;
  logic                  fifoWin;
  logic [NUM_REGS-1:0]   setMask;
  logic [NUM_REGS-1:0]   clrMask;
  logic [NUM_REGS-1:0]   busyMask;
  logic                  wbWriteEnable;
  logic [REG_ADDR_W-1:0] wbWriteReg;
  logic [DATA_W-1:0]     wbData;

  assign pushEntry    = '{rd: bus.md_rd, data: bus.md_data};
  assign bus.md_ready = !fifoFull && ctrl_reset;
  assign fifoPush     = bus.md_valid && bus.md_ready;
  assign bus.alu_ready = !starveFlag;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) resultFifo (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .push      (fifoPush),
    .pushEntry (pushEntry),
    .pop       (fifoWin),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .head      (fifoHead)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starveCnt;

  assign starveFlag = (starveCnt == StarveW'(STARVE_LIMIT));

  // Count ALU wins that leave a buffered result waiting; saturate at the limit.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      starveCnt <= '0;
    end else if (fifoWin || fifoEmpty) begin
      starveCnt <= '0;
    end else if (aluWin && !starveFlag) begin
      starveCnt <= starveCnt + StarveW'(1);
    end
  end
`else
  assign starveFlag = 1'b0;
`endif

  // Pick this cycle's winner: starved head first, then ALU, then any buffered head.
  always_comb begin
    aluWin  = 1'b0;
    fifoWin = 1'b0;
    if (starveFlag && !fifoEmpty) begin
      fifoWin = 1'b1;
    end else if (bus.alu_valid) begin
      aluWin = 1'b1;
    end else if (!fifoEmpty) begin
      fifoWin = 1'b1;
    end
  end

  // Scoreboard updates: an issue marks its register busy, a head pop releases it.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (bus.md_issue && bus.md_issue_rd != '0) setMask[bus.md_issue_rd] = 1'b1;
    if (fifoWin) clrMask[fifoHead.rd] = 1'b1;
  end

  // Register the busy mask; a set on the same register overrides a clear.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      busyMask <= '0;
    end else begin
      busyMask <= (busyMask & ~clrMask) | setMask;
    end
  end

  // Register the write port; r0 winners are consumed silently and idle cycles hold the bus.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wbWriteEnable <= 1'b0;
      wbWriteReg    <= '0;
      wbData        <= '0;
    end else begin
      wbWriteEnable <= 1'b0;
      if (aluWin && bus.alu_rd != '0) begin
        wbWriteEnable <= 1'b1;
        wbWriteReg    <= bus.alu_rd;
        wbData        <= bus.alu_data;
      end else if (fifoWin && fifoHead.rd != '0) begin
        wbWriteEnable <= 1'b1;
        wbWriteReg    <= fifoHead.rd;
        wbData        <= fifoHead.data;
      end
    end
  end

  assign bus.wb_writeEnable = wbWriteEnable;
  assign bus.wb_writeReg    = wbWriteReg;
  assign bus.wb_data        = wbData;
  assign bus.busy_mask      = busyMask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: randomized traffic against a queue-based
// reference model, with a scoreboard monitor on the write port.
`timescale 1ns/1ps
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b0;

  wb_arbiter_if bus();

  wb_arbiter #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        expQ[$];
  wb_entry_t   mdQ[$];
  int          starveCnt = 0;
  bit [31:0]   busy = '0;
  bit          inReset = 1'b1;
  bit          holdKnown = 1'b0;
  logic [4:0]  lastReg = '0;
  logic [31:0] lastData = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of traffic: drive inputs at the negedge, then advance the model.
  task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                               input bit mv, input logic [4:0] mrd, input logic [31:0] mdata,
                               input bit iss, input logic [4:0] issRd);
    bit        starve;
    bit        mdRdy;
    int        sizeBefore;
    bit        fifoWon;
    bit        aluWon;
    wb_entry_t h;
    @(negedge clock);
    checkOutput("busy_mask", bus.busy_mask, busy);
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_data    = adata;
    bus.md_valid    = mv;
    bus.md_rd       = mrd;
    bus.md_data     = mdata;
    bus.md_issue    = iss;
    bus.md_issue_rd = issRd;
    #1;
    sizeBefore = mdQ.size();
    starve     = GUARD && (starveCnt == STARVE_LIMIT);
    mdRdy      = (sizeBefore < FIFO_DEPTH);
    checkOutput("alu_ready", {31'b0, bus.alu_ready}, {31'b0, !starve});
    checkOutput("md_ready", {31'b0, bus.md_ready}, {31'b0, mdRdy});
    fifoWon = 1'b0;
    aluWon  = 1'b0;
    if (starve && sizeBefore > 0) fifoWon = 1'b1;
    else if (av) aluWon = 1'b1;
    else if (sizeBefore > 0) fifoWon = 1'b1;
    if (fifoWon) begin
      h = mdQ.pop_front();
      busy[h.rd] = 1'b0;
      expQ.push_back('{cyc + 1, (h.rd != 0), h.rd, h.data});
    end else if (aluWon) begin
      expQ.push_back('{cyc + 1, (ard != 0), ard, adata});
    end
    if (fifoWon || sizeBefore == 0) starveCnt = 0;
    else if (aluWon && starveCnt < STARVE_LIMIT) starveCnt++;
    if (mv && mdRdy) mdQ.push_back('{rd: mrd, data: mdata});
    if (iss && issRd != 0) busy[issRd] = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic releaseReset();
    @(negedge clock);
    ctrl_reset = 1'b1;
    inReset    = 1'b0;
    holdKnown  = 1'b1;
    lastReg    = '0;
    lastData   = '0;
  endtask

  // Pulse reset in the middle of a cycle and check the outputs clear immediately.
  task automatic resetPulse();
    @(negedge clock);
    bus.alu_valid = 1'b0;
    bus.md_valid  = 1'b0;
    bus.md_issue  = 1'b0;
    #2;
    ctrl_reset = 1'b0;
    inReset    = 1'b1;
    #1;
    checkOutput("rst wb_writeEnable", {31'b0, bus.wb_writeEnable}, 32'd0);
    checkOutput("rst wb_writeReg", {27'b0, bus.wb_writeReg}, 32'd0);
    checkOutput("rst wb_data", bus.wb_data, 32'd0);
    checkOutput("rst busy_mask", bus.busy_mask, 32'd0);
    checkOutput("rst md_ready", {31'b0, bus.md_ready}, 32'd0);
    checkOutput("rst alu_ready", {31'b0, bus.alu_ready}, 32'd1);
    mdQ.delete();
    expQ.delete();
    busy      = '0;
    starveCnt = 0;
    @(posedge clock);
    releaseReset();
  endtask

  // Scoreboard monitor: match each write-port cycle against the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (!inReset) begin
        if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
          e = expQ.pop_front();
          checkOutput("wb_writeEnable", {31'b0, bus.wb_writeEnable}, {31'b0, e.we});
          if (e.we) begin
            checkOutput("wb_writeReg", {27'b0, bus.wb_writeReg}, {27'b0, e.rd});
            checkOutput("wb_data", bus.wb_data, e.data);
            lastReg   = e.rd;
            lastData  = e.data;
            holdKnown = 1'b1;
          end else begin
            holdKnown = 1'b0;
          end
        end else begin
          checkOutput("idle wb_writeEnable", {31'b0, bus.wb_writeEnable}, 32'd0);
          if (holdKnown) begin
            checkOutput("hold wb_writeReg", {27'b0, bus.wb_writeReg}, {27'b0, lastReg});
            checkOutput("hold wb_data", bus.wb_data, lastData);
          end
        end
      end
    end
  end

  initial begin
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.md_valid    = 1'b0;
    bus.md_rd       = '0;
    bus.md_data     = '0;
    bus.md_issue    = 1'b0;
    bus.md_issue_rd = '0;
    #12;
    checkOutput("init wb_writeEnable", {31'b0, bus.wb_writeEnable}, 32'd0);
    checkOutput("init busy_mask", bus.busy_mask, 32'd0);
    checkOutput("init md_ready", {31'b0, bus.md_ready}, 32'd0);
    checkOutput("init alu_ready", {31'b0, bus.alu_ready}, 32'd1);
    releaseReset();

    // Plain ALU write, then an r0 ALU result that must not write.
    applyStimulus(1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    idleCycles(2);

    // Issue to r7, return its result on an idle ALU, watch the busy bit clear.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7);
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h0000_1234, 0, 0);
    idleCycles(3);

    // Fill the buffer while the ALU keeps the port busy.
    applyStimulus(1, 5'd1, 32'h1111_0001, 1, 5'd9, 32'h0000_0009, 1, 5'd9);
    applyStimulus(1, 5'd2, 32'h1111_0002, 1, 5'd10, 32'h0000_000A, 1, 5'd10);
    for (int i = 0; i < 14; i++) applyStimulus(1, 5'(i + 3), 32'h2222_0000 + i, 1, 5'd11, 32'hBEEF, 0, 0);
    idleCycles(4);

    // Leave one buffered result for r3 and reset underneath it.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3);
    applyStimulus(1, 5'd4, 32'h4444_4444, 1, 5'd3, 32'h3333_3333, 0, 0);
    resetPulse();
    idleCycles(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
      if (i == 200) resetPulse();
    end
    idleCycles(FIFO_DEPTH + 4);
    checkOutput("expected writes drained", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
